core_loader: RTL and testbench

Core-side receiver for the scheduler-to-core message bus; one instance per GPU core. It decodes the 16-bit message stream and its qualifier flags (core mask, R0 mask, R0 data, instruction words), captures only what is addressed to its core, and fills a local instruction buffer and the core's initial R0 register. It then hands the task to the core's execute stage and reports readiness back to the scheduler through `core_reading`/`core_ready`.

---
 rtl/core_loader_pkg.sv | 35 +++
 rtl/core_loader_if.sv | 40 ++++
 rtl/core_loader_instr_buf.sv | 39 +++
 rtl/core_loader.sv | 200 ++++++++++++++++++++
 tb/tb_core_loader.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_loader_pkg
// Purpose : Shared loader definitions: state encoding, bus width, flag helper.
// Rev     : 1.0  initial release
// ============================================================================
package core_loader_pkg;

    localparam int SCHED_MSG_BUS_WIDTH = 16;
    localparam int DEFAULT_IDLE_GAP    = 4;

    typedef enum logic [2:0] {
        LOADER_IDLE  = 3'd0,
        LOADER_SEL   = 3'd1,
        LOADER_R0    = 3'd2,
        LOADER_INSTR = 3'd3,
        LOADER_RUN   = 3'd4
    } loader_state_t;

    typedef struct packed {
        logic core_mask;
        logic r0_mask;
        logic r0;
        logic instr;
    } msg_flags_t;

    // More than one qualifier high in the same cycle is a bus protocol violation.
    function automatic logic flags_conflict(input msg_flags_t f);
        logic [3:0] v;
        v = f;
        return |(v & (v - 4'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : core_loader_if
// Purpose : Scheduler-to-core message bus as seen by one core.
// Rev     : 1.0  initial release
// ============================================================================
interface core_loader_if
    import core_loader_pkg::*;
#(
    parameter int BUS_TO_CORE = SCHED_MSG_BUS_WIDTH
);
    logic [BUS_TO_CORE-1:0] mess_to_core;
    logic                   core_mask_loading;
    logic                   r0_mask_loading;
    logic                   r0_loading;
    logic                   instr_loading;
    logic                   core_reading;
    logic                   core_ready;

    modport master (
        output mess_to_core,
        output core_mask_loading,
        output r0_mask_loading,
        output r0_loading,
        output instr_loading,
        input  core_reading,
        input  core_ready
    );

    modport slave (
        input  mess_to_core,
        input  core_mask_loading,
        input  r0_mask_loading,
        input  r0_loading,
        input  instr_loading,
        output core_reading,
        output core_ready
    );
endinterface
`default_nettype wire

// File: rtl/core_loader_instr_buf.sv
`default_nettype none
// ============================================================================
// Module  : instr_buf
// Purpose : Instruction RAM, one write port, registered read (old-data on RAW).
// Rev     : 1.0  initial release
// ============================================================================
module instr_buf #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_loader.sv
`default_nettype none
// ============================================================================
// Module  : core_loader
// Purpose : Per-core receiver: decodes the scheduler message stream, loads R0
//           and the instruction buffer, then hands the task to execute.
// Rev     : 1.0  initial release
// ============================================================================
module core_loader
    import core_loader_pkg::*;
#(
    parameter int CORE_ID      = 0,
    parameter int CORE_NUM     = 16,
    parameter int BUS_TO_CORE  = SCHED_MSG_BUS_WIDTH,
    parameter int R0_DATA_SIZE = 128,
    parameter int IMEM_DEPTH   = 1024,
    parameter int IDLE_GAP     = DEFAULT_IDLE_GAP,
    parameter int R0_WORDS     = R0_DATA_SIZE / BUS_TO_CORE,
    parameter int IMEM_AW      = $clog2(IMEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    core_loader_if.slave            bus,
    input  logic                    exec_done,
    input  logic [IMEM_AW-1:0]      imem_raddr,
    output logic [BUS_TO_CORE-1:0]  imem_rdata,
    output logic                    exec_start,
    output logic [IMEM_AW:0]        instr_count,
    output logic [R0_DATA_SIZE-1:0] r0_data,
    output logic                    r0_valid,
    output logic                    proto_err
);

    localparam int c_idx_w = $clog2(R0_WORDS + 1);
    localparam int c_gap_w = $clog2(IDLE_GAP + 1);
    localparam logic [IMEM_AW:0] c_imem_full = IMEM_DEPTH[IMEM_AW:0];

    if (CORE_ID >= CORE_NUM || CORE_NUM > BUS_TO_CORE) begin : g_bad_cfg
        $error("core_loader: CORE_ID must be below CORE_NUM and CORE_NUM must fit in the bus word");
    end

    loader_state_t           r_state;
    logic [c_idx_w-1:0]      r_r0_idx;
    logic                    r_r0_sel;
    logic [c_gap_w-1:0]      r_gap;
    logic [IMEM_AW:0]        r_instr_count;
    logic [R0_DATA_SIZE-1:0] r_r0_data;
    logic                    r_r0_valid;
    logic                    r_proto_err;
    logic                    r_exec_start;
    logic                    r_core_reading;
    logic                    r_core_ready;

    msg_flags_t w_flags;
    logic       w_conflict;
    logic       w_any;
    logic       w_hit;
    logic       w_mask;
    logic       w_r0_mask;
    logic       w_r0;
    logic       w_instr;
    logic       w_full;
    logic       w_imem_we;

    assign w_flags    = {bus.core_mask_loading, bus.r0_mask_loading,
                         bus.r0_loading, bus.instr_loading};
    assign w_conflict = flags_conflict(w_flags);
    assign w_any      = |w_flags;
    assign w_hit      = bus.mess_to_core[CORE_ID];
    // A conflicting cycle qualifies nothing; only the error flag reacts to it.
    assign w_mask     = w_flags.core_mask & ~w_conflict;
    assign w_r0_mask  = w_flags.r0_mask   & ~w_conflict;
    assign w_r0       = w_flags.r0        & ~w_conflict;
    assign w_instr    = w_flags.instr     & ~w_conflict;
    assign w_full     = (r_instr_count == c_imem_full);
    assign w_imem_we  = w_instr & ~w_full &
                        ((r_state == LOADER_R0) || (r_state == LOADER_INSTR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= LOADER_IDLE;
            r_r0_idx       <= '0;
            r_r0_sel       <= 1'b0;
            r_gap          <= '0;
            r_instr_count  <= '0;
            r_r0_data      <= '0;
            r_r0_valid     <= 1'b0;
            r_proto_err    <= 1'b0;
            r_exec_start   <= 1'b0;
            r_core_reading <= 1'b1;
            r_core_ready   <= 1'b1;
        end else begin
            r_exec_start <= 1'b0;
            if (w_conflict) begin
                r_proto_err <= 1'b1;
            end
            if (w_imem_we) begin
                r_instr_count <= r_instr_count + (IMEM_AW + 1)'(1);
            end

            case (r_state)
                LOADER_IDLE: begin
                    if (w_mask && w_hit) begin
                        r_state       <= LOADER_SEL;
                        r_instr_count <= '0;
                        r_r0_valid    <= 1'b0;
                        r_r0_idx      <= '0;
                        r_core_ready  <= 1'b0;
                    end
                end

                LOADER_SEL: begin
                    if (w_r0_mask) begin
                        r_r0_sel <= w_hit;
                        r_state  <= LOADER_R0;
                    end
                end

                LOADER_R0: begin
                    if (w_r0) begin
                        // Index saturates so the scheduler's padding words fall away.
                        if (r_r0_idx < c_idx_w'(R0_WORDS)) begin
                            r_r0_idx <= r_r0_idx + c_idx_w'(1);
                            if (r_r0_sel) begin
                                for (int i = 0; i < R0_WORDS; i++) begin
                                    if (r_r0_idx == c_idx_w'(i)) begin
                                        r_r0_data[i*BUS_TO_CORE +: BUS_TO_CORE] <= bus.mess_to_core;
                                    end
                                end
                                if (r_r0_idx == c_idx_w'(R0_WORDS - 1)) begin
                                    r_r0_valid <= 1'b1;
                                end
                            end
                        end
                    end else if (w_instr) begin
                        r_state <= LOADER_INSTR;
                        r_gap   <= '0;
                    end
                end

                LOADER_INSTR: begin
                    if (w_mask) begin
                        r_state        <= LOADER_RUN;
                        r_exec_start   <= 1'b1;
                        r_core_reading <= 1'b0;
                    end else if (w_any) begin
                        r_gap <= '0;
                        if (w_instr && w_full) begin
                            r_proto_err <= 1'b1;
                        end
                    end else if (r_gap == c_gap_w'(IDLE_GAP - 1)) begin
                        r_state        <= LOADER_RUN;
                        r_exec_start   <= 1'b1;
                        r_core_reading <= 1'b0;
                    end else begin
                        r_gap <= r_gap + c_gap_w'(1);
                    end
                end

                LOADER_RUN: begin
                    if (w_mask && w_hit) begin
                        r_proto_err <= 1'b1;
                    end
                    if (exec_done) begin
                        r_state        <= LOADER_IDLE;
                        r_core_reading <= 1'b1;
                        r_core_ready   <= 1'b1;
                    end
                end

                default: begin
                    r_state <= LOADER_IDLE;
                end
            endcase
        end
    end

    instr_buf #(
        .DEPTH  (IMEM_DEPTH),
        .WIDTH  (BUS_TO_CORE),
        .ADDR_W (IMEM_AW)
    ) u_instr_buf (
        .clk   (clk),
        .reset (reset),
        .we    (w_imem_we),
        .waddr (r_instr_count[IMEM_AW-1:0]),
        .wdata (bus.mess_to_core),
        .raddr (imem_raddr),
        .rdata (imem_rdata)
    );

    assign bus.core_reading = r_core_reading;
    assign bus.core_ready   = r_core_ready;
    assign exec_start       = r_exec_start;
    assign instr_count      = r_instr_count;
    assign r0_data          = r_r0_data;
    assign r0_valid         = r_r0_valid;
    assign proto_err        = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_core_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_core_loader
// Purpose : Randomized self-checking bench for core_loader (CORE_ID = 3).
// Rev     : 1.0  initial release
// ============================================================================
module tb_core_loader;

    localparam int CORE_ID = 3;
    localparam int BUS     = 16;
    localparam int R0W     = 8;
    localparam int DEPTH   = 1024;
    localparam int AW      = 10;
    localparam int GAP     = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           exec_done = 1'b0;
    logic [AW-1:0]  imem_raddr = '0;
    logic [BUS-1:0] imem_rdata;
    logic           exec_start;
    logic [AW:0]    instr_count;
    logic [127:0]   r0_data;
    logic           r0_valid;
    logic           proto_err;

    core_loader_if #(.BUS_TO_CORE(BUS)) bus ();

    core_loader #(
        .CORE_ID      (CORE_ID),
        .CORE_NUM     (16),
        .BUS_TO_CORE  (BUS),
        .R0_DATA_SIZE (128),
        .IMEM_DEPTH   (DEPTH),
        .IDLE_GAP     (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .exec_done   (exec_done),
        .imem_raddr  (imem_raddr),
        .imem_rdata  (imem_rdata),
        .exec_start  (exec_start),
        .instr_count (instr_count),
        .r0_data     (r0_data),
        .r0_valid    (r0_valid),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what the task-level rules say the core should hold.
    logic [127:0] m_r0;
    bit           m_r0_valid;
    int           m_cnt;
    bit           m_proto;
    logic [15:0]  m_mem [DEPTH];
    bit           m_known [DEPTH];

    int n_start = 0;
    bit watch_idle = 1'b0;
    bit idle_viol = 1'b0;

    always @(posedge clk) if (exec_start === 1'b1) n_start++;
    always @(negedge clk)
        if (watch_idle && (bus.core_ready !== 1'b1 || bus.core_reading !== 1'b1 || exec_start !== 1'b0))
            idle_viol = 1'b1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags = {core_mask, r0_mask, r0, instr}; word stays on the bus afterwards
    task automatic send(input logic [3:0] flags, input logic [15:0] word);
        bus.mess_to_core      = word;
        bus.core_mask_loading = flags[3];
        bus.r0_mask_loading   = flags[2];
        bus.r0_loading        = flags[1];
        bus.instr_loading     = flags[0];
        tick();
        bus.core_mask_loading = 1'b0;
        bus.r0_mask_loading   = 1'b0;
        bus.r0_loading        = 1'b0;
        bus.instr_loading     = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " reading"},  bus.core_reading, 1);
        check({tag, " ready"},    bus.core_ready, 1);
        check({tag, " start"},    exec_start, 0);
        check({tag, " count"},    instr_count, 0);
        check({tag, " r0_data"},  r0_data, 0);
        check({tag, " r0_valid"}, r0_valid, 0);
        check({tag, " proto"},    proto_err, 0);
        check({tag, " rdata"},    imem_rdata, 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #2;
        check_reset_vals(tag);
        m_r0 = '0; m_r0_valid = 1'b0; m_cnt = 0; m_proto = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic finish_exec(input string tag);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check({tag, " done ready"},   bus.core_ready, 1);
        check({tag, " done reading"}, bus.core_reading, 1);
    endtask

    task automatic readback(input string tag, input int n);
        for (int a = 0; a < n; a++) begin
            imem_raddr = AW'(a);
            tick();
            if (m_known[a]) check({tag, " readback"}, imem_rdata, m_mem[a]);
        end
    endtask

    task automatic run_task(input string tag, input logic [15:0] cmask, input logic [15:0] r0mask,
                            input int n_instr, input bit fixed_r0, input bit stalls,
                            input bit multi, input bit end_mask, input int abort_at);
        bit          sel, r0sel;
        int          starts0, s;
        logic [15:0] w;
        logic [AW-1:0] ra;
        sel     = cmask[CORE_ID];
        starts0 = n_start;
        send(4'b1000, cmask);
        if (sel) begin m_cnt = 0; m_r0_valid = 1'b0; end
        send(4'b0100, r0mask);
        r0sel = sel && r0mask[CORE_ID];
        for (int i = 0; i < R0W + 5; i++) begin
            if (multi && i == 3) begin
                send(4'b0011, 16'hdead);
                m_proto = 1'b1;
            end
            w = (fixed_r0 && i < R0W) ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
            send(4'b0010, w);
            if (r0sel && i < R0W) begin
                m_r0[16*i +: 16] = w;
                if (i == R0W - 1) m_r0_valid = 1'b1;
            end
        end
        for (int j = 0; j < n_instr; j++) begin
            if (j == abort_at) return;
            if (stalls) begin
                s = (j == 2) ? $urandom_range(1, 3) : $urandom_range(0, 3);
                for (int k = 0; k < s; k++) begin
                    exec_done = (j == 2 && k == 0);
                    tick();
                end
                exec_done = 1'b0;
            end
            ra = AW'(m_cnt);
            imem_raddr = ra;
            w = 16'($urandom);
            send(4'b0001, w);
            if (stalls && sel && m_cnt < DEPTH && m_known[m_cnt])
                check({tag, " rd_during_wr"}, imem_rdata, m_mem[m_cnt]);
            if (sel) begin
                if (m_cnt < DEPTH) begin
                    m_mem[m_cnt] = w; m_known[m_cnt] = 1'b1; m_cnt++;
                end else begin
                    m_proto = 1'b1;
                end
            end
        end
        if (end_mask) begin
            send(4'b1000, 16'h0001);
            check({tag, " start_on_mask"}, exec_start, sel);
        end else begin
            repeat (GAP - 1) tick();
            check({tag, " start_early"}, exec_start, 0);
            tick();
            check({tag, " start_on_gap"}, exec_start, sel);
        end
        check({tag, " reading"}, bus.core_reading, !sel);
        check({tag, " ready"},   bus.core_ready, !sel);
        tick();
        check({tag, " start_width"}, exec_start, 0);
        check({tag, " start_count"}, n_start - starts0, sel);
        check({tag, " count"},    instr_count, m_cnt);
        check({tag, " r0_valid"}, r0_valid, m_r0_valid);
        check({tag, " r0_data"},  r0_data, m_r0);
        check({tag, " proto"},    proto_err, m_proto);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r0_pat;
        r0_pat = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
        bus.mess_to_core = '0;
        bus.core_mask_loading = 1'b0;
        bus.r0_mask_loading = 1'b0;
        bus.r0_loading = 1'b0;
        bus.instr_loading = 1'b0;
        #3;
        do_reset("por");

        watch_idle = 1'b1;
        run_task("nosel", 16'h0004, 16'h0008, 20, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        watch_idle = 1'b0;
        check("nosel idle_held", idle_viol, 0);

        run_task("r0off", 16'h0008, 16'h0004, 10, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        readback("r0off", 10);
        finish_exec("r0off");

        run_task("main", 16'h0008, 16'h0008, 20, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        check("main r0_pattern", r0_data, r0_pat);
        readback("main", 20);
        send(4'b1000, 16'h0004);
        check("run other mask proto", proto_err, 0);
        finish_exec("main");

        run_task("ovf", 16'h0008, 16'h0008, DEPTH + 1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("ovf count", instr_count, DEPTH);
        finish_exec("ovf");

        run_task("abort", 16'h0008, 16'h0008, 30, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        do_reset("midload");
        run_task("after_rst", 16'h0808, 16'h0008, 40, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        readback("after_rst", 40);
        finish_exec("after_rst");

        do_reset("rst2");
        run_task("mask_end", 16'h0008, 16'h0008, 3, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send(4'b1000, 16'h0008);
        m_proto = 1'b1;
        check("run own mask proto", proto_err, m_proto);
        finish_exec("mask_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
